// File: rtl/mmio_timer_target.sv
// Memory-mapped timer/scratch responder on the shared 64-bit bus: snoops requests,
// applies writes in place and returns read responses through the vld/gnt handshake.
module mmio_timer_target #(
  parameter logic [14:0] MM_BASE    = 15'h7020,
  parameter logic [31:0] INTV       = 32'd15,
  parameter int unsigned RESP_DELAY = 2,
  parameter logic [1:0]  SRC_ID     = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] bus,
  output logic        bus_vld,
  output logic [63:0] bus_out,
  input  logic        bus_gnt,
  output logic        interrupt,
  output logic [31:0] intv
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ} state_t;

  localparam logic [3:0] DLY_INIT = 4'(RESP_DELAY);

  state_t      state_q, state_d;
  logic [3:0]  dly_q, dly_d;
  logic [63:0] act_q, act_d;
  logic [63:0] buf_q, buf_d;
  logic        buf_vld_q, buf_vld_d;

  logic [31:0] scratch_q, scratch_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  status_q, status_d;

  logic        is_req;
  logic        hit;
  logic        rd_hit;
  logic        wr_hit;
  logic [1:0]  off;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [63:0] resp_word;
  logic        match;
  logic        drop;
  logic        hold_busy;

  // Size field, pad bits and our own id play no part in decoding; SRC_ID is only
  // meaningful to agents that originate requests.
  logic unused_bits;
  assign unused_bits = ^{bus[57:55], bus[39:32], SRC_ID};

  assign is_req = (bus[62:60] == 3'b001) || (bus[62:60] == 3'b010);
  assign hit    = bus[63] && is_req && (bus[54:42] == MM_BASE[14:2]);
  assign rd_hit = hit && (bus[62:60] == 3'b001);
  assign wr_hit = hit && (bus[62:60] == 3'b010);
  assign off    = bus[41:40];
  assign wdata  = bus[31:0];

  always_comb begin
    rdata = '0;
    case (off)
      2'd0: rdata = scratch_q;
      2'd1: rdata = {30'd0, ctrl_q};
      2'd2: rdata = count_q;
      2'd3: rdata = {30'd0, status_q};
      default: rdata = '0;
    endcase
  end

  assign resp_word = {1'b1, 3'b011, bus[59:58], 3'b010, bus[54:40], 8'h00, rdata};
  assign match     = ctrl_q[1] && (count_q == scratch_q);

  always_comb begin
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    status_d  = status_q;
    if (ctrl_q[0]) count_d = count_q + 32'd1;
    if (wr_hit) begin
      case (off)
        2'd0: scratch_d = wdata;
        2'd1: ctrl_d    = wdata[1:0];
        2'd2: count_d   = wdata;
        2'd3: status_d  = status_q & ~wdata[1:0];
        default: ;
      endcase
    end
    // Set sources are applied after the W1C so a same-cycle set wins.
    if (match) status_d[0] = 1'b1;
    if (drop)  status_d[1] = 1'b1;
  end

  // While the active entry stays busy this cycle, a read hit goes to the buffer.
  assign hold_busy = (state_q == S_WAIT) || ((state_q == S_REQ) && !bus_gnt);

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    act_d     = act_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    drop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_hit) begin
          act_d   = resp_word;
          dly_d   = DLY_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        dly_d = dly_q - 4'd1;
        if (dly_q == 4'd1) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus_gnt) begin
          // The granted entry leaves this cycle, so a concurrent hit has room.
          if (buf_vld_q) begin
            act_d     = buf_q;
            dly_d     = DLY_INIT;
            state_d   = S_WAIT;
            buf_vld_d = rd_hit;
            if (rd_hit) buf_d = resp_word;
          end else if (rd_hit) begin
            act_d   = resp_word;
            dly_d   = DLY_INIT;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (hold_busy && rd_hit) begin
      if (!buf_vld_q) begin
        buf_d     = resp_word;
        buf_vld_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      act_q     <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      scratch_q <= '0;
      ctrl_q    <= '0;
      count_q   <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      act_q     <= act_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      status_q  <= status_d;
    end
  end

  assign bus_vld   = (state_q == S_REQ);
  assign bus_out   = bus_vld ? act_q : '0;
  assign interrupt = status_q[0];
  assign intv      = INTV;

endmodule

// File: tb/tb_mmio_timer_target.sv
// Directed bench for mmio_timer_target: register access, counter wrap, compare
// interrupt, response queueing/overrun, reset flush and address filtering.
module tb_mmio_timer_target;

  logic        clk;
  logic        rst;
  logic [63:0] bus;
  logic        bus_vld;
  logic [63:0] bus_out;
  logic        bus_gnt;
  logic        interrupt;
  logic [31:0] intv;

  int total;
  int bad;

  localparam logic [14:0] BASE = 15'h7020;

  mmio_timer_target #(
    .MM_BASE(15'h7020),
    .INTV(32'd15),
    .RESP_DELAY(2),
    .SRC_ID(2'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .bus_vld(bus_vld),
    .bus_out(bus_out),
    .bus_gnt(bus_gnt),
    .interrupt(interrupt),
    .intv(intv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mkw(input logic [2:0] typ, input logic [1:0] id,
                                      input logic [14:0] addr, input logic [31:0] data);
    return {1'b1, typ, id, 3'b010, addr, 8'h00, data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic [63:0] w);
    bus = w;
    step();
    bus = '0;
  endtask

  task automatic wr(input logic [1:0] id, input logic [1:0] o, input logic [31:0] d);
    bus_cycle(mkw(3'b010, id, BASE + 15'(o), d));
  endtask

  task automatic rd_issue(input logic [1:0] id, input logic [1:0] o);
    bus_cycle(mkw(3'b001, id, BASE + 15'(o), 32'd0));
  endtask

  task automatic wait_resp(output logic [63:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int i = 0; i < 30; i++) begin
      if (bus_vld) begin
        w = bus_out;
        ok = 1'b1;
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic read_reg(input logic [1:0] id, input logic [1:0] o,
                          output logic [31:0] d, output bit ok);
    logic [63:0] w;
    rd_issue(id, o);
    wait_resp(w, ok);
    d = w[31:0];
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bit ok;
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    total++; if (bus_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", bus_vld); end
    total++; if (bus_out !== 64'd0) begin bad++; $display("FAIL rst_out got=%h exp=0", bus_out); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", interrupt); end
    total++; if (intv !== 32'd15) begin bad++; $display("FAIL intv got=%0d exp=15", intv); end
    for (int r = 0; r < 4; r++) begin
      read_reg(2'd1, 2'(r), d, ok);
      total++;
      if (!ok || d !== 32'd0) begin bad++; $display("FAIL rst_reg%0d ok=%b got=%h exp=0", r, ok, d); end
    end
  endtask

  task automatic test_scratch();
    wr(2'd1, 2'd0, 32'hDEADBEEF);
    rd_issue(2'd1, 2'd0);
    total++; if (bus_vld !== 1'b0) begin bad++; $display("FAIL lat_t1 got=%b exp=0", bus_vld); end
    step();
    total++; if (bus_vld !== 1'b0) begin bad++; $display("FAIL lat_t2 got=%b exp=0", bus_vld); end
    step();
    total++; if (bus_vld !== 1'b1) begin bad++; $display("FAIL lat_t3 got=%b exp=1", bus_vld); end
    total++; if (bus_out !== 64'hB570_2000_DEAD_BEEF) begin
      bad++; $display("FAIL scratch_word got=%h exp=b5702000deadbeef", bus_out); end
    step();
    total++; if (bus_vld !== 1'b1 || bus_out !== 64'hB570_2000_DEAD_BEEF) begin
      bad++; $display("FAIL hold_no_gnt vld=%b out=%h exp vld=1 stable", bus_vld, bus_out); end
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    total++; if (bus_vld !== 1'b0) begin bad++; $display("FAIL drop_after_gnt got=%b exp=0", bus_vld); end
  endtask

  task automatic test_count();
    logic [63:0] w;
    logic [31:0] d;
    bit ok;
    wr(2'd1, 2'd1, 32'd1);
    wr(2'd1, 2'd2, 32'hFFFF_FFFE);
    bus_cycle('0);
    rd_issue(2'd1, 2'd2);
    rd_issue(2'd2, 2'd2);
    wait_resp(w, ok);
    total++; if (!ok || w[31:0] !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL count_ffff ok=%b got=%h exp=ffffffff", ok, w[31:0]); end
    wait_resp(w, ok);
    total++; if (!ok || w[31:0] !== 32'd0 || w[59:58] !== 2'd2) begin
      bad++; $display("FAIL count_wrap ok=%b got=%h dest=%0d exp=0 dest=2", ok, w[31:0], w[59:58]); end
    wr(2'd1, 2'd2, 32'h100);
    read_reg(2'd1, 2'd2, d, ok);
    total++; if (!ok || d !== 32'h100) begin
      bad++; $display("FAIL count_load ok=%b got=%h exp=100", ok, d); end
    wr(2'd1, 2'd1, 32'd0);
  endtask

  task automatic test_match_irq();
    int rise;
    wr(2'd1, 2'd0, 32'd10);
    wr(2'd1, 2'd2, 32'd0);
    wr(2'd1, 2'd1, 32'd3);
    rise = -1;
    for (int i = 0; i < 30; i++) begin
      if (interrupt) begin rise = i; break; end
      step();
    end
    total++; if (rise != 11) begin bad++; $display("FAIL irq_rise got=%0d exp=11", rise); end
    total++; if (intv !== 32'd15) begin bad++; $display("FAIL irq_intv got=%0d exp=15", intv); end
    wr(2'd1, 2'd3, 32'd1);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", interrupt); end
    wr(2'd1, 2'd1, 32'd2);
    wr(2'd1, 2'd2, 32'd10);
    step();
    total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL irq_static got=%b exp=1", interrupt); end
    wr(2'd1, 2'd3, 32'd1);
    total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", interrupt); end
    wr(2'd1, 2'd1, 32'd0);
    wr(2'd1, 2'd3, 32'd1);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_off got=%b exp=0", interrupt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bit ok;
    bit extra;
    rd_issue(2'd1, 2'd0);
    rd_issue(2'd2, 2'd2);
    rd_issue(2'd1, 2'd1);
    total++; if (bus_vld !== 1'b1 || bus_out !== mkw(3'b011, 2'd1, 15'h7020, 32'd10)) begin
      bad++; $display("FAIL b2b_first vld=%b got=%h exp=%h", bus_vld, bus_out, mkw(3'b011, 2'd1, 15'h7020, 32'd10)); end
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    total++; if (bus_vld !== 1'b0) begin bad++; $display("FAIL b2b_gap1 got=%b exp=0", bus_vld); end
    step();
    total++; if (bus_vld !== 1'b0) begin bad++; $display("FAIL b2b_gap2 got=%b exp=0", bus_vld); end
    step();
    total++; if (bus_vld !== 1'b1 || bus_out !== mkw(3'b011, 2'd2, 15'h7022, 32'd10)) begin
      bad++; $display("FAIL b2b_second vld=%b got=%h exp=%h", bus_vld, bus_out, mkw(3'b011, 2'd2, 15'h7022, 32'd10)); end
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    extra = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus_vld) extra = 1'b1;
      step();
    end
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL b2b_third_dropped got=%b exp=0", extra); end
    read_reg(2'd1, 2'd3, d, ok);
    total++; if (!ok || d !== 32'h2) begin bad++; $display("FAIL overrun ok=%b got=%h exp=2", ok, d); end
    wr(2'd1, 2'd3, 32'h2);
    read_reg(2'd1, 2'd3, d, ok);
    total++; if (!ok || d !== 32'h0) begin bad++; $display("FAIL overrun_clr ok=%b got=%h exp=0", ok, d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit ok;
    bit seen;
    rd_issue(2'd1, 2'd0);
    rst = 1'b1;
    bus = mkw(3'b010, 2'd1, 15'h7020, 32'h55);
    step();
    rst = 1'b0;
    bus = '0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus_vld) seen = 1'b1;
      step();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_vld got=%b exp=0", seen); end
    for (int r = 0; r < 4; r++) begin
      read_reg(2'd1, 2'(r), d, ok);
      total++;
      if (!ok || d !== 32'd0) begin bad++; $display("FAIL rst_mid_reg%0d ok=%b got=%h exp=0", r, ok, d); end
    end
  endtask

  task automatic test_ignore();
    logic [31:0] d;
    logic [63:0] w;
    bit ok;
    bit seen;
    wr(2'd1, 2'd0, 32'hA5A5);
    bus_cycle(mkw(3'b010, 2'd1, 15'h7024, 32'hFFFF));
    bus_cycle(mkw(3'b001, 2'd1, 15'h7024, 32'h0));
    bus_cycle(mkw(3'b011, 2'd1, 15'h7020, 32'h1234));
    w = mkw(3'b010, 2'd1, 15'h7020, 32'h9999);
    w[63] = 1'b0;
    bus_cycle(w);
    w = mkw(3'b001, 2'd1, 15'h7020, 32'h0);
    w[63] = 1'b0;
    bus_cycle(w);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus_vld) seen = 1'b1;
      step();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ignore_vld got=%b exp=0", seen); end
    read_reg(2'd2, 2'd0, d, ok);
    total++; if (!ok || d !== 32'hA5A5) begin bad++; $display("FAIL ignore_scratch ok=%b got=%h exp=a5a5", ok, d); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus = '0;
    bus_gnt = 1'b0;
    test_reset();
    test_scratch();
    test_count();
    test_match_irq();
    test_back_to_back();
    test_reset_mid();
    test_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
